instr_decoder: RTL and testbench

INSTR_DECODER -- requirements
Module: instr_decoder

---
 rtl/instr_decoder_pkg.sv | 53 +++++
 rtl/instr_param_regs.sv | 82 ++++++++
 rtl/instr_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_instr_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder_pkg
// Purpose  : Shared widths, opcodes, PARAM IDs, target codes and FSM state
//            encodings for the instruction decoder and its register file.
// Revision : 1.0 - initial release
// ============================================================================
package instr_decoder_pkg;

  localparam int BIT_INSTR = 32;
  localparam int BIT_PSUM  = 16;
  localparam int BIT_STATE = 3;
  localparam int BIT_PID   = 20;

  // Instruction opcodes (bits [30:28]); 6 and 7 decode as no-ops
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PARAM   = 3'd1,
    OP_WBPARAM = 3'd2,
    OP_WRITE   = 3'd3,
    OP_EX      = 3'd4,
    OP_WBPSRAM = 3'd5,
    OP_RSV6    = 3'd6,
    OP_RSV7    = 3'd7
  } opcode_t;

  // PARAM register IDs (bits [27:8])
  localparam logic [BIT_PID-1:0] PID_S          = 20'h00000;
  localparam logic [BIT_PID-1:0] PID_IC         = 20'h00001;
  localparam logic [BIT_PID-1:0] PID_IC_WH      = 20'h00002;
  localparam logic [BIT_PID-1:0] PID_OC         = 20'h00003;
  localparam logic [BIT_PID-1:0] PID_BASE_WSRAM = 20'h00004;
  localparam logic [BIT_PID-1:0] PID_TRG        = 20'h00005;

  // Load-target codes carried in DATA of a PARAM_TRG word
  localparam logic [7:0] TRG_ISRAM = 8'h00;
  localparam logic [7:0] TRG_WSRAM = 8'h01;

  // Decoder FSM states, also exported on the debug port
  typedef enum logic [BIT_STATE-1:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_RDREQ  = 3'd2,
    ST_RDWAIT = 3'd3
  } state_t;

  // Opcodes that hold off the instruction source until they complete
  function automatic logic is_blocking_op(input opcode_t op);
    return (op == OP_EX) || (op == OP_WBPSRAM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_param_regs.sv
`default_nettype none
// ============================================================================
// Module   : instr_param_regs
// Purpose  : PARAM register file (S, IC, IC_WH, OC, BASE_WSRAM, load target)
//            with the combinational read mux used by WBPARAM.
// Revision : 1.0 - initial release
// ============================================================================
module instr_param_regs
  import instr_decoder_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               i_wr_en,
  input  logic [BIT_PID-1:0] i_id,
  input  logic [7:0]         i_wr_data,
  output logic [7:0]         o_param_s,
  output logic [7:0]         o_param_ic,
  output logic [7:0]         o_param_ic_wh,
  output logic [7:0]         o_param_oc,
  output logic [7:0]         o_base_wsram,
  output logic               o_target_wsram,
  output logic [7:0]         o_rd_data
);

  logic [7:0] r_param_s;
  logic [7:0] r_param_ic;
  logic [7:0] r_param_ic_wh;
  logic [7:0] r_param_oc;
  logic [7:0] r_base_wsram;
  logic       r_target_wsram;

  // Register writes; unknown IDs and unknown target codes leave state alone
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_param_s      <= 8'h00;
      r_param_ic     <= 8'h00;
      r_param_ic_wh  <= 8'h00;
      r_param_oc     <= 8'h00;
      r_base_wsram   <= 8'h00;
      r_target_wsram <= 1'b0;
    end else if (i_wr_en) begin
      case (i_id)
        PID_S:          r_param_s     <= i_wr_data;
        PID_IC:         r_param_ic    <= i_wr_data;
        PID_IC_WH:      r_param_ic_wh <= i_wr_data;
        PID_OC:         r_param_oc    <= i_wr_data;
        PID_BASE_WSRAM: r_base_wsram  <= i_wr_data;
        PID_TRG: begin
          if (i_wr_data == TRG_WSRAM) begin
            r_target_wsram <= 1'b1;
          end else if (i_wr_data == TRG_ISRAM) begin
            r_target_wsram <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux for WBPARAM; the target reads back as its TRG code
  always_comb begin
    o_rd_data = 8'h00;
    case (i_id)
      PID_S:          o_rd_data = r_param_s;
      PID_IC:         o_rd_data = r_param_ic;
      PID_IC_WH:      o_rd_data = r_param_ic_wh;
      PID_OC:         o_rd_data = r_param_oc;
      PID_BASE_WSRAM: o_rd_data = r_base_wsram;
      PID_TRG:        o_rd_data = r_target_wsram ? TRG_WSRAM : TRG_ISRAM;
      default:        o_rd_data = 8'h00;
    endcase
  end

  assign o_param_s      = r_param_s;
  assign o_param_ic     = r_param_ic;
  assign o_param_ic_wh  = r_param_ic_wh;
  assign o_param_oc     = r_param_oc;
  assign o_base_wsram   = r_base_wsram;
  assign o_target_wsram = r_target_wsram;

endmodule
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Decodes strobed 32-bit instruction words into PARAM updates,
//            SRAM load strobes, execute handshakes and PSRAM/param writeback.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic [BIT_INSTR-1:0] i_Instr_In,
  input  logic                 i_instr_pulse,
  output logic                 instr_stall,
  output logic [7:0]           o_param_s,
  output logic [7:0]           o_param_ic,
  output logic [7:0]           o_param_ic_wh,
  output logic [7:0]           o_param_oc,
  output logic [7:0]           o_base_wsram,
  output logic                 o_isram_we,
  output logic                 o_wsram_we,
  output logic [3:0]           o_sram_sel,
  output logic [15:0]          o_sram_addr,
  output logic [7:0]           o_sram_din,
  output logic                 o_ex_start,
  input  logic                 i_ex_done,
  output logic                 o_psram_re,
  output logic [3:0]           o_psram_bank,
  output logic [15:0]          o_psram_addr,
  input  logic [BIT_PSUM-1:0]  i_psram_rdata,
  output logic                 o_Flag_Finish_Out,
  output logic                 o_Valid_WB_Out,
  output logic [BIT_PSUM-1:0]  o_Data_WB_Out,
  output logic [BIT_STATE-1:0] o_state_debug
);

  // Instruction field split
  logic               w_opvalid;
  opcode_t            w_op;
  logic [BIT_PID-1:0] w_pid;
  logic [3:0]         w_sel;
  logic [15:0]        w_addr;
  logic [7:0]         w_data;

  assign w_opvalid = i_Instr_In[31];
  assign w_op      = opcode_t'(i_Instr_In[30:28]);
  assign w_pid     = i_Instr_In[27:8];
  assign w_sel     = i_Instr_In[27:24];
  assign w_addr    = i_Instr_In[23:8];
  assign w_data    = i_Instr_In[7:0];

  state_t r_state;
  state_t w_state_nxt;
  logic   w_idle;
  logic   w_accept;

  // Words are only acted on while idle; anything else is a protocol error
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = i_instr_pulse & w_opvalid & w_idle;

  logic       w_param_wr;
  logic       w_target_wsram;
  logic [7:0] w_rd_data;

  assign w_param_wr = w_accept & (w_op == OP_PARAM);

  instr_param_regs u_param_regs (
    .CLK            (CLK),
    .RSTb           (RSTb),
    .i_wr_en        (w_param_wr),
    .i_id           (w_pid),
    .i_wr_data      (w_data),
    .o_param_s      (o_param_s),
    .o_param_ic     (o_param_ic),
    .o_param_ic_wh  (o_param_ic_wh),
    .o_param_oc     (o_param_oc),
    .o_base_wsram   (o_base_wsram),
    .o_target_wsram (w_target_wsram),
    .o_rd_data      (w_rd_data)
  );

  logic w_ex_start_nxt;
  logic w_psram_re_nxt;
  logic w_finish_set;
  logic w_finish_clr;
  logic w_rd_capture;

  // Next-state and handshake decisions for the blocking opcodes
  always_comb begin
    w_state_nxt    = r_state;
    w_ex_start_nxt = 1'b0;
    w_psram_re_nxt = 1'b0;
    w_finish_set   = 1'b0;
    w_finish_clr   = 1'b0;
    w_rd_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_op == OP_EX)) begin
          w_state_nxt    = ST_EXEC;
          w_ex_start_nxt = 1'b1;
          w_finish_clr   = 1'b1;
        end else if (w_accept && (w_op == OP_WBPSRAM)) begin
          w_state_nxt    = ST_RDREQ;
          w_psram_re_nxt = 1'b1;
        end
      end
      ST_EXEC: begin
        if (i_ex_done) begin
          w_state_nxt  = ST_IDLE;
          w_finish_set = 1'b1;
        end
      end
      ST_RDREQ:  w_state_nxt = ST_RDWAIT;
      ST_RDWAIT: begin
        // Read data is valid in this cycle, one cycle after the request
        w_state_nxt  = ST_IDLE;
        w_rd_capture = 1'b1;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  logic r_ex_start;
  logic r_psram_re;
  logic r_flag_finish;

  // State register plus the registered execute/read strobes and finish flag
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state       <= ST_IDLE;
      r_ex_start    <= 1'b0;
      r_psram_re    <= 1'b0;
      r_flag_finish <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ex_start <= w_ex_start_nxt;
      r_psram_re <= w_psram_re_nxt;
      if (w_finish_set) begin
        r_flag_finish <= 1'b1;
      end else if (w_finish_clr) begin
        r_flag_finish <= 1'b0;
      end
    end
  end

  logic [3:0]  r_psram_bank;
  logic [15:0] r_psram_addr;

  // PSRAM read address, latched with the read request
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_psram_bank <= 4'h0;
      r_psram_addr <= 16'h0000;
    end else if (w_psram_re_nxt) begin
      r_psram_bank <= w_sel;
      r_psram_addr <= w_addr;
    end
  end

  logic        r_isram_we;
  logic        r_wsram_we;
  logic [3:0]  r_sram_sel;
  logic [15:0] r_sram_addr;
  logic [7:0]  r_sram_din;
  logic        w_write;

  assign w_write = w_accept & (w_op == OP_WRITE);

  // SRAM load: one-cycle strobe to the selected target with latched fields
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_isram_we  <= 1'b0;
      r_wsram_we  <= 1'b0;
      r_sram_sel  <= 4'h0;
      r_sram_addr <= 16'h0000;
      r_sram_din  <= 8'h00;
    end else begin
      r_isram_we <= w_write & ~w_target_wsram;
      r_wsram_we <= w_write &  w_target_wsram;
      if (w_write) begin
        r_sram_sel  <= w_sel;
        r_sram_addr <= w_addr;
        r_sram_din  <= w_data;
      end
    end
  end

  logic                r_valid_wb;
  logic [BIT_PSUM-1:0] r_data_wb;

  // Writeback port; PSRAM capture wins, though the FSM keeps the two apart
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_valid_wb <= 1'b0;
      r_data_wb  <= '0;
    end else begin
      r_valid_wb <= 1'b0;
      if (w_rd_capture) begin
        r_valid_wb <= 1'b1;
        r_data_wb  <= i_psram_rdata;
      end else if (w_accept && (w_op == OP_WBPARAM)) begin
        r_valid_wb <= 1'b1;
        r_data_wb  <= {{(BIT_PSUM-8){1'b0}}, w_rd_data};
      end
    end
  end

  logic [7:0] r_proto_err_cnt;

  // Saturating count of words that arrived while busy (debug visibility)
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_proto_err_cnt <= 8'h00;
    end else if (i_instr_pulse && !w_idle && (r_proto_err_cnt != 8'hFF)) begin
      r_proto_err_cnt <= r_proto_err_cnt + 8'd1;
    end
  end

  // Stall covers the accepting cycle of a blocking word, so it is partly
  // combinational; held low while reset is asserted
  assign instr_stall = RSTb & (~w_idle |
                               (i_instr_pulse & w_opvalid & is_blocking_op(w_op)));

  assign o_isram_we        = r_isram_we;
  assign o_wsram_we        = r_wsram_we;
  assign o_sram_sel        = r_sram_sel;
  assign o_sram_addr       = r_sram_addr;
  assign o_sram_din        = r_sram_din;
  assign o_ex_start        = r_ex_start;
  assign o_psram_re        = r_psram_re;
  assign o_psram_bank      = r_psram_bank;
  assign o_psram_addr      = r_psram_addr;
  assign o_Flag_Finish_Out = r_flag_finish;
  assign o_Valid_WB_Out    = r_valid_wb;
  assign o_Data_WB_Out     = r_data_wb;
  assign o_state_debug     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decoder
// Purpose  : Self-checking bench for instr_decoder: directed scenarios plus a
//            randomized stream checked against a small behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decoder;
  import instr_decoder_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b1;
  logic [31:0] i_Instr_In = '0;
  logic        i_instr_pulse = 1'b0;
  logic        instr_stall;
  logic [7:0]  o_param_s, o_param_ic, o_param_ic_wh, o_param_oc, o_base_wsram;
  logic        o_isram_we, o_wsram_we;
  logic [3:0]  o_sram_sel;
  logic [15:0] o_sram_addr;
  logic [7:0]  o_sram_din;
  logic        o_ex_start;
  logic        i_ex_done = 1'b0;
  logic        o_psram_re;
  logic [3:0]  o_psram_bank;
  logic [15:0] o_psram_addr;
  logic [15:0] i_psram_rdata = 16'hDEAD;
  logic        o_Flag_Finish_Out, o_Valid_WB_Out;
  logic [15:0] o_Data_WB_Out;
  logic [2:0]  o_state_debug;

  instr_decoder dut (
    .CLK(CLK), .RSTb(RSTb), .i_Instr_In(i_Instr_In), .i_instr_pulse(i_instr_pulse),
    .instr_stall(instr_stall), .o_param_s(o_param_s), .o_param_ic(o_param_ic),
    .o_param_ic_wh(o_param_ic_wh), .o_param_oc(o_param_oc), .o_base_wsram(o_base_wsram),
    .o_isram_we(o_isram_we), .o_wsram_we(o_wsram_we), .o_sram_sel(o_sram_sel),
    .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din), .o_ex_start(o_ex_start),
    .i_ex_done(i_ex_done), .o_psram_re(o_psram_re), .o_psram_bank(o_psram_bank),
    .o_psram_addr(o_psram_addr), .i_psram_rdata(i_psram_rdata),
    .o_Flag_Finish_Out(o_Flag_Finish_Out), .o_Valid_WB_Out(o_Valid_WB_Out),
    .o_Data_WB_Out(o_Data_WB_Out), .o_state_debug(o_state_debug)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: five parameters plus the load target (0 = ISRAM, 1 = WSRAM)
  logic [7:0] m_par [0:5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    i_Instr_In    = w;
    i_instr_pulse = 1'b1;
    tick();
    i_instr_pulse = 1'b0;
    i_Instr_In    = '0;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [19:0] fld,
                                     input logic [7:0] d);
    return {1'b1, op, fld, d};
  endfunction

  function automatic logic [7:0] m_read(input logic [19:0] id);
    if (id < 20'd6) return m_par[id[2:0]];
    return 8'h00;
  endfunction

  task automatic m_param(input logic [19:0] id, input logic [7:0] d);
    if (id < 20'd5) m_par[id[2:0]] = d;
    else if (id == 20'd5 && d <= 8'd1) m_par[5] = d;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 6; k++) m_par[k] = 8'h00;
  endtask

  task automatic chk_params(input string tag);
    chk({tag, ".s"},     32'(o_param_s),     32'(m_par[0]));
    chk({tag, ".ic"},    32'(o_param_ic),    32'(m_par[1]));
    chk({tag, ".ic_wh"}, 32'(o_param_ic_wh), 32'(m_par[2]));
    chk({tag, ".oc"},    32'(o_param_oc),    32'(m_par[3]));
    chk({tag, ".base"},  32'(o_base_wsram),  32'(m_par[4]));
  endtask

  initial begin
    logic [31:0] w;
    logic [19:0] id;
    logic [7:0]  d;
    logic [15:0] rd;
    int          kind;
    int          r;
    int          starts;
    int          stall_lo;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_iwe;
    logic        exp_wwe;

    m_reset();

    // ---- reset: async entry, stall forced low even with a blocking pulse
    #2 RSTb = 1'b0;
    i_Instr_In    = mk(3'd4, 20'h0, 8'h0);
    i_instr_pulse = 1'b1;
    #1 chk("rst.stall", 32'(instr_stall), 32'd0);
    repeat (3) tick();
    i_instr_pulse = 1'b0;
    i_Instr_In    = '0;
    chk("rst.state", 32'(o_state_debug), 32'd0);
    chk("rst.valid", 32'(o_Valid_WB_Out), 32'd0);
    chk("rst.data", 32'(o_Data_WB_Out), 32'd0);
    chk("rst.flag", 32'(o_Flag_Finish_Out), 32'd0);
    chk("rst.ex_start", 32'(o_ex_start), 32'd0);
    chk_params("rst");
    RSTb = 1'b1;
    tick();

    // ---- PARAM loads, each visible one cycle after its pulse
    send(mk(3'd1, PID_S, 8'd1));     m_param(PID_S, 8'd1);     chk_params("p_s");
    send(mk(3'd1, PID_IC, 8'd16));   m_param(PID_IC, 8'd16);   chk_params("p_ic");
    send(mk(3'd1, PID_IC_WH, 8'd3)); m_param(PID_IC_WH, 8'd3); chk_params("p_icwh");
    send(mk(3'd1, PID_OC, 8'd128));  m_param(PID_OC, 8'd128);  chk_params("p_oc");

    // ---- WBPARAM OC: one-cycle valid with zero-extended value
    send(mk(3'd2, PID_OC, 8'h00));
    chk("wbp.valid", 32'(o_Valid_WB_Out), 32'd1);
    chk("wbp.data", 32'(o_Data_WB_Out), 32'd128);
    tick();
    chk("wbp.valid_drop", 32'(o_Valid_WB_Out), 32'd0);

    // ---- target WSRAM, then WRITE
    send(mk(3'd1, PID_TRG, TRG_WSRAM)); m_param(PID_TRG, TRG_WSRAM);
    send(mk(3'd3, {4'd2, 16'h0010}, 8'hA5));
    chk("wr.wsram_we", 32'(o_wsram_we), 32'd1);
    chk("wr.isram_we", 32'(o_isram_we), 32'd0);
    chk("wr.sel", 32'(o_sram_sel), 32'd2);
    chk("wr.addr", 32'(o_sram_addr), 32'h10);
    chk("wr.din", 32'(o_sram_din), 32'hA5);
    tick();
    chk("wr.wsram_we_drop", 32'(o_wsram_we), 32'd0);
    chk("wr.isram_we_idle", 32'(o_isram_we), 32'd0);

    // ---- EX: stall on the accepting cycle, start pulse, wait for done
    i_Instr_In    = mk(3'd4, 20'h0, 8'h0);
    i_instr_pulse = 1'b1;
    #1 chk("ex.stall_comb", 32'(instr_stall), 32'd1);
    tick();
    i_instr_pulse = 1'b0;
    i_Instr_In    = '0;
    chk("ex.start", 32'(o_ex_start), 32'd1);
    chk("ex.state", 32'(o_state_debug), 32'd1);
    chk("ex.flag", 32'(o_Flag_Finish_Out), 32'd0);
    // A word arriving while busy must be dropped
    send(mk(3'd1, PID_S, 8'h77));
    chk("ex.busy_param", 32'(o_param_s), 32'(m_par[0]));
    starts   = 0;
    stall_lo = 0;
    for (int k = 0; k < 48; k++) begin
      if (o_ex_start) starts++;
      if (!instr_stall) stall_lo++;
      tick();
    end
    chk("ex.extra_starts", 32'(starts), 32'd0);
    chk("ex.stall_gaps", 32'(stall_lo), 32'd0);
    i_ex_done = 1'b1;
    tick();
    i_ex_done = 1'b0;
    chk("ex.done_state", 32'(o_state_debug), 32'd0);
    chk("ex.done_flag", 32'(o_Flag_Finish_Out), 32'd1);
    chk("ex.done_stall", 32'(instr_stall), 32'd0);
    send(mk(3'd0, PID_S, 8'h55));
    chk_params("nop");
    chk("nop.valid", 32'(o_Valid_WB_Out), 32'd0);
    i_ex_done = 1'b1;
    tick();
    i_ex_done = 1'b0;
    chk("stray_done.state", 32'(o_state_debug), 32'd0);
    chk("stray_done.flag", 32'(o_Flag_Finish_Out), 32'd1);
    chk("stray_done.start", 32'(o_ex_start), 32'd0);

    // ---- WBPSRAM bank 3 addr 31, data returned one cycle after re
    send(mk(3'd5, {4'd3, 16'd31}, 8'h00));
    chk("rd.re", 32'(o_psram_re), 32'd1);
    chk("rd.bank", 32'(o_psram_bank), 32'd3);
    chk("rd.addr", 32'(o_psram_addr), 32'd31);
    chk("rd.stall", 32'(instr_stall), 32'd1);
    tick();
    chk("rd.re_drop", 32'(o_psram_re), 32'd0);
    chk("rd.state_wait", 32'(o_state_debug), 32'd3);
    i_psram_rdata = 16'h1234;
    tick();
    i_psram_rdata = 16'hDEAD;
    chk("rd.valid", 32'(o_Valid_WB_Out), 32'd1);
    chk("rd.data", 32'(o_Data_WB_Out), 32'h1234);
    chk("rd.stall_rel", 32'(instr_stall), 32'd0);
    tick();
    chk("rd.valid_drop", 32'(o_Valid_WB_Out), 32'd0);

    // ---- randomized stream against the model
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 9));
      r    = int'($urandom_range(0, 9));
      id   = (r == 9) ? 20'h10003 : 20'(r);
      d    = 8'($urandom);
      if (id == PID_TRG && $urandom_range(0, 1) == 1) d = {7'b0, d[0]};
      if (kind == 6) begin
        w  = mk(3'd5, {4'($urandom), 16'($urandom)}, 8'h00);
        rd = 16'($urandom);
        send(w);
        chk("rnd.rd_re", 32'(o_psram_re), 32'd1);
        chk("rnd.rd_bank", 32'(o_psram_bank), 32'(w[27:24]));
        chk("rnd.rd_addr", 32'(o_psram_addr), 32'(w[23:8]));
        tick();
        i_psram_rdata = rd;
        tick();
        i_psram_rdata = 16'hDEAD;
        chk("rnd.rd_valid", 32'(o_Valid_WB_Out), 32'd1);
        chk("rnd.rd_data", 32'(o_Data_WB_Out), 32'(rd));
      end else begin
        case (kind)
          0, 1, 2: w = mk(3'd1, id, d);
          3:       w = mk(3'd2, id, d);
          4, 5:    w = mk(3'd3, 20'($urandom), d);
          7:       w = mk(3'd0, id, d);
          8:       w = {1'b0, 31'($urandom)};
          default: w = mk(3'($urandom_range(6, 7)), id, d);
        endcase
        exp_v   = w[31] && (w[30:28] == 3'd2);
        exp_d   = {8'h00, m_read(w[27:8])};
        exp_iwe = w[31] && (w[30:28] == 3'd3) && (m_par[5] == 8'd0);
        exp_wwe = w[31] && (w[30:28] == 3'd3) && (m_par[5] == 8'd1);
        send(w);
        if (w[31] && w[30:28] == 3'd1) m_param(w[27:8], w[7:0]);
        chk_params("rnd");
        chk("rnd.valid", 32'(o_Valid_WB_Out), 32'(exp_v));
        if (exp_v) chk("rnd.wb_data", 32'(o_Data_WB_Out), 32'(exp_d));
        chk("rnd.isram_we", 32'(o_isram_we), 32'(exp_iwe));
        chk("rnd.wsram_we", 32'(o_wsram_we), 32'(exp_wwe));
        if (exp_iwe || exp_wwe) begin
          chk("rnd.sel", 32'(o_sram_sel), 32'(w[27:24]));
          chk("rnd.addr", 32'(o_sram_addr), 32'(w[23:8]));
          chk("rnd.din", 32'(o_sram_din), 32'(w[7:0]));
        end
      end
    end

    // ---- reset during EXEC aborts cleanly
    send(mk(3'd4, 20'h0, 8'h0));
    chk("rx.state", 32'(o_state_debug), 32'd1);
    chk("rx.flag_cleared", 32'(o_Flag_Finish_Out), 32'd0);
    repeat (3) tick();
    #2 RSTb = 1'b0;
    #1;
    m_reset();
    chk("rx.state_rst", 32'(o_state_debug), 32'd0);
    chk("rx.stall_rst", 32'(instr_stall), 32'd0);
    chk("rx.flag_rst", 32'(o_Flag_Finish_Out), 32'd0);
    chk("rx.valid_rst", 32'(o_Valid_WB_Out), 32'd0);
    chk_params("rx");
    tick();
    RSTb = 1'b1;
    i_ex_done = 1'b1;
    tick();
    i_ex_done = 1'b0;
    chk("rx.flag_after_done", 32'(o_Flag_Finish_Out), 32'd0);
    chk("rx.state_after", 32'(o_state_debug), 32'd0);

    // ---- OPVALID=0 and reserved opcode leave everything unchanged
    send(mk(3'd1, PID_S, 8'h5A)); m_param(PID_S, 8'h5A);
    chk_params("iv.setup");
    send({1'b0, 3'd1, PID_S, 8'h33});
    chk_params("iv.novalid");
    chk("iv.novalid_wb", 32'(o_Valid_WB_Out), 32'd0);
    i_Instr_In    = mk(3'd7, PID_S, 8'h44);
    i_instr_pulse = 1'b1;
    #1 chk("iv.op7_stall", 32'(instr_stall), 32'd0);
    tick();
    i_instr_pulse = 1'b0;
    i_Instr_In    = '0;
    chk_params("iv.op7");
    chk("iv.op7_wb", 32'(o_Valid_WB_Out), 32'd0);
    chk("iv.op7_we", 32'({o_isram_we, o_wsram_we}), 32'd0);
    chk("iv.op7_state", 32'(o_state_debug), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
